// File: rtl/sram_arbiter.sv
// Arbitrates one single-port SRAM/bus slave between instruction fetch
// and load/store, with data priority, stall requests and an ack watchdog.
module sram_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_ready,
    output logic              inst_err,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [3:0]        data_sel,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_ready,
    output logic              data_err,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [3:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              stallreq_if,
    output logic              stallreq_mem
);

    typedef enum logic [1:0] {IDLE, INST, DATA} state_t;

    // Counter value at which an unacknowledged access gets aborted.
    localparam logic [7:0] LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       data_grant;
    logic       inst_grant;

    // A port pulsing ready still shows its old request this cycle.
    assign data_grant   = data_req && !data_ready;
    assign inst_grant   = inst_req && !inst_ready;
    assign stallreq_if  = inst_grant;
    assign stallreq_mem = data_grant;

    // Arbitration FSM with registered memory and completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            inst_rdata <= '0;
            inst_ready <= 1'b0;
            inst_err   <= 1'b0;
            data_rdata <= '0;
            data_ready <= 1'b0;
            data_err   <= 1'b0;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            mem_sel    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            inst_ready <= 1'b0;
            inst_err   <= 1'b0;
            data_ready <= 1'b0;
            data_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (data_grant) begin
                        state     <= DATA;
                        mem_ce    <= 1'b1;
                        mem_we    <= data_we;
                        mem_sel   <= data_sel;
                        mem_addr  <= data_addr;
                        mem_wdata <= data_wdata;
                    end else if (inst_grant) begin
                        state     <= INST;
                        mem_ce    <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_sel   <= 4'b1111;
                        mem_addr  <= inst_addr;
                        mem_wdata <= '0;
                    end else begin
                        mem_ce <= 1'b0;
                    end
                end
                INST, DATA: begin
                    if (mem_ack) begin
                        state  <= IDLE;
                        mem_ce <= 1'b0;
                        cnt    <= '0;
                        if (state == INST) begin
                            inst_ready <= 1'b1;
                            inst_rdata <= mem_rdata;
                        end else begin
                            data_ready <= 1'b1;
                            if (!mem_we) data_rdata <= mem_rdata;
                        end
                    end else if (cnt == LAST) begin
                        state  <= IDLE;
                        mem_ce <= 1'b0;
                        cnt    <= '0;
                        if (state == INST) begin
                            inst_ready <= 1'b1;
                            inst_err   <= 1'b1;
                            inst_rdata <= '0;
                        end else begin
                            data_ready <= 1'b1;
                            data_err   <= 1'b1;
                            data_rdata <= '0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    mem_ce <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares one single-port SRAM/bus slave between the IF stage (instruction fetch) and the MEM stage (load/store).
- Sequences each access with a req/ready handshake toward the stages and a ce/ack handshake toward memory.
- Raises stall requests into the pipeline stall controller, which freezes the stages while an access is outstanding.
- Data accesses have fixed priority over fetches. A watchdog aborts accesses that memory never acknowledges.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 255, maximum cycles in an access state before abort. Legal range is 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- inst_req  in  1  fetch request, held until inst_ready.
- inst_addr  in  ADDR_W  fetch address.
- inst_rdata  out  DATA_W  fetched word.
- inst_ready  out  1  one-cycle completion pulse.
- inst_err  out  1  timeout flag, valid with inst_ready.
- data_req  in  1  load/store request, held until data_ready.
- data_we  in  1  1 = store.
- data_sel  in  4  byte enables.
- data_addr  in  ADDR_W  load/store address.
- data_wdata  in  DATA_W  store data.
- data_rdata  out  DATA_W  load data.
- data_ready  out  1  one-cycle completion pulse.
- data_err  out  1  timeout flag, valid with data_ready.
- mem_ce  out  1  memory access active.
- mem_we  out  1  memory write enable.
- mem_sel  out  4  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completion, one cycle.
- stallreq_if  out  1  stall request from the fetch side.
- stallreq_mem  out  1  stall request from the load/store side.

Behaviour:
- FSM states: IDLE, INST, DATA. All outputs are registered except stallreq_if and stallreq_mem.
- Reset: state=IDLE, timeout counter=0. All outputs are 0, including the rdata registers and the mem_* fields.
- IDLE transitions:
  - Grant conditions are data_req && !data_ready and inst_req && !inst_ready. A port pulsing ready this cycle is holding a stale request, so it is ignored.
  - Data grant has priority over fetch grant.
  - Data grant: go to DATA. Latch mem_we=data_we, mem_sel=data_sel, mem_addr=data_addr, mem_wdata=data_wdata. Set mem_ce=1.
  - Fetch grant: go to INST. Latch mem_addr=inst_addr, mem_we=0, mem_sel=4'b1111, mem_wdata=0. Set mem_ce=1.
  - No grant: stay in IDLE with mem_ce=0.
- INST/DATA behaviour:
  - mem_* outputs hold stable and the counter increments each cycle.
  - On mem_ack: return to IDLE, mem_ce=0, counter=0. Pulse the matching ready for one cycle with err=0.
  - On a read, capture mem_rdata into the matching rdata. On a store, data_rdata is unchanged.
- Timeout: if the counter reaches TIMEOUT_CYC-1 without mem_ack, return to IDLE. Pulse the matching ready with err=1 and set rdata=0. A mem_ack arriving in that same cycle takes precedence, giving a normal completion.
- No preemption: a data_req that arrives during INST waits until the fetch completes. Mem_ack while in IDLE is ignored.
- Latency: a request sampled at edge N gives mem_ce=1 in cycle N+1. An ack in cycle M gives ready in cycle M+1. The minimum request-to-ready time is 2 cycles, plus a 1-cycle IDLE gap between back-to-back accesses.
- Rdata holds its value until the next completion on the same port.
- Stall requests: stallreq_if = inst_req && !inst_ready; stallreq_mem = data_req && !data_ready. Both are combinational and deassert in the ready cycle.
- Reset mid-access: the access is abandoned immediately. No ready pulse is generated and mem_ce drops on the next edge.

Test Plan:
1. Lone fetch: inst_req=1, addr=0x100, ack 3 cycles after ce, rdata=0xDEADBEEF -> mem_ce high 3 cycles; inst_ready pulse 1 cycle with inst_rdata=0xDEADBEEF, inst_err=0; stallreq_if high until the ready cycle.
2. Simultaneous requests: inst_req and data_req (load 0x200) both rise in the same cycle -> DATA granted first with mem_addr=0x200, mem_we=0; after data_ready, one IDLE cycle, then INST.
3. Store: data_we=1, sel=4'b0011, wdata=0x1234 -> mem_we=1, mem_sel=4'b0011, mem_wdata=0x1234; data_ready pulses and data_rdata is unchanged.
4. Data during fetch: data_req rises while in INST -> the fetch completes first, then the data access; mem_addr never changes mid-access.
5. Timeout: TIMEOUT_CYC=4, no ack -> mem_ce high 4 cycles, then data_ready=1 and data_err=1 with data_rdata=0; a later access works normally.
6. Reset mid-access: rst asserted in DATA -> next cycle state IDLE, mem_ce=0, no ready pulse, all outputs 0.
